// File: rtl/mult_seq_if.sv
// Signal bundle between the multiply sequencer and the execute stage / shared ALU mux.
// start is a one-cycle request, sampled only while the sequencer is idle or done;
// done pulses for exactly one cycle, and product stays valid until the next done.
interface mult_seq_if;
    logic        start;
    logic        cancel;
    logic [0:31] a;
    logic [0:31] b;
    logic [0:31] alu_result;
    logic        alu_req;
    logic [0:31] alu_a;
    logic [0:31] alu_b;
    logic [0:3]  alu_ctrl;
    logic        busy;
    logic        done;
    logic [0:31] product;
    logic [1:0]  state_dbg;

    modport master (
        output start, cancel, a, b, alu_result,
        input  alu_req, alu_a, alu_b, alu_ctrl, busy, done, product, state_dbg
    );

    modport slave (
        input  start, cancel, a, b, alu_result,
        output alu_req, alu_a, alu_b, alu_ctrl, busy, done, product, state_dbg
    );
endinterface

// File: rtl/mult_seq.sv
// Iterative 32-bit shift/add multiplier that borrows the pipeline ALU for 64 cycles.
// Returns the low 32 bits of a*b, which are the same for signed and unsigned operands.
module mult_seq (
    input  logic        clk,
    input  logic        reset,
    mult_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_SHL  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [0:3] ALU_ADD = 4'b0000;
    localparam logic [0:3] ALU_SLL = 4'b1001;

    state_e      state_q, state_d;
    logic [0:31] acc_q, acc_d;
    logic [0:31] mcand_q, mcand_d;
    logic [0:31] mplier_q, mplier_d;
    logic [0:4]  iter_q, iter_d;
    logic [0:31] product_q, product_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            iter_q    <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            iter_q    <= iter_d;
            product_q <= product_d;
        end
    end

    // Next state and register updates; a cancel drops this cycle's updates entirely.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        iter_d    = iter_q;
        product_d = product_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    acc_d    = '0;
                    mcand_d  = bus.a;
                    mplier_d = bus.b;
                    iter_d   = '0;
                    state_d  = S_ADD;
                end
            end
            S_ADD: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d   = bus.alu_result;
                    state_d = S_SHL;
                end
            end
            S_SHL: begin
                if (bus.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    mcand_d  = bus.alu_result;
                    mplier_d = mplier_q >> 1;
                    if (iter_q == 5'd31) begin
                        product_d = acc_q;
                        state_d   = S_DONE;
                    end else begin
                        iter_d  = iter_q + 5'd1;
                        state_d = S_ADD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs depend only on registered state, never on start/cancel/alu_result.
    always_comb begin
        bus.alu_req   = 1'b0;
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_ctrl  = ALU_ADD;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            S_ADD: begin
                bus.alu_req  = 1'b1;
                bus.busy     = 1'b1;
                bus.alu_ctrl = ALU_ADD;
                bus.alu_a    = acc_q;
                bus.alu_b    = mplier_q[31] ? mcand_q : '0;
            end
            S_SHL: begin
                bus.alu_req  = 1'b1;
                bus.busy     = 1'b1;
                bus.alu_ctrl = ALU_SLL;
                bus.alu_a    = mcand_q;
                bus.alu_b    = 32'd1;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.product   = product_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: behavioural ALU, hand-computed product table,
// latency/ownership counting, back-to-back, async reset and cancel scenarios.
module tb_mult_seq;

  logic clk = 1'b0;
  logic reset;

  mult_seq_if bus();

  mult_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Behavioural shared ALU: add, and shift-left by B[27:31].
  always_comb begin
    case (bus.alu_ctrl)
      4'b0000: bus.alu_result = bus.alu_a + bus.alu_b;
      4'b1001: bus.alu_result = bus.alu_a << bus.alu_b[27:31];
      default: bus.alu_result = '0;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  logic [31:0] c1_ctrl, c1_b, c2_ctrl, c2_a, c2_b, c3_ctrl, c3_b;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in IDLE, 1 time unit after an edge (this is cycle 0).
  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp, prev;
    int busy_n, req_n, done_n;
    exp = exp_q.pop_front();
    prev = bus.product;
    busy_n = 0; req_n = 0; done_n = 0;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      if (bus.busy) busy_n++;
      if (bus.alu_req) req_n++;
      if (bus.done) done_n++;
      if (c == 1) begin c1_ctrl = 32'(bus.alu_ctrl); c1_b = bus.alu_b; end
      if (c == 2) begin c2_ctrl = 32'(bus.alu_ctrl); c2_a = bus.alu_a; c2_b = bus.alu_b; end
      if (c == 3) begin c3_ctrl = 32'(bus.alu_ctrl); c3_b = bus.alu_b; end
      if (c == 64) check_eq({tag, " product held c64"}, bus.product, prev);
      step();
    end
    check_eq({tag, " busy cycles"}, 32'(busy_n), 32'd64);
    check_eq({tag, " alu_req cycles"}, 32'(req_n), 32'd64);
    check_eq({tag, " early done"}, 32'(done_n), 32'd0);
    check_eq({tag, " done c65"}, 32'(bus.done), 32'd1);
    check_eq({tag, " alu_req c65"}, 32'(bus.alu_req), 32'd0);
    check_eq({tag, " product"}, bus.product, exp);
    step();
    check_eq({tag, " done c66"}, 32'(bus.done), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  localparam int NV = 6;
  logic [31:0] va [NV] = '{32'd3, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h00010000, 32'h00000000, 32'h00001234};
  logic [31:0] vb [NV] = '{32'd5, 32'd7,        32'hFFFFFFFF, 32'h00010000, 32'h12345678, 32'h00000002};
  logic [31:0] vp [NV] = '{32'd15, 32'hFFFFFFEB, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00002468};

  initial begin
    int d1, d2, dn;
    bus.start = 1'b0;
    bus.cancel = 1'b0;
    bus.a = '0;
    bus.b = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst alu_req", 32'(bus.alu_req), 32'd0);
    check_eq("rst busy", 32'(bus.busy), 32'd0);
    check_eq("rst done", 32'(bus.done), 32'd0);
    check_eq("rst product", bus.product, 32'd0);
    check_eq("rst alu_a", bus.alu_a, 32'd0);
    check_eq("rst alu_b", bus.alu_b, 32'd0);
    check_eq("rst alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    check_eq("rst state", 32'(bus.state_dbg), 32'd0);
    reset = 1'b0;
    step();

    // Directed product table
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(vp[i]);
      run_mult($sformatf("vec%0d", i), va[i], vb[i]);
    end
    // Last vector has b=2: per-cycle ALU drive
    check_eq("b2 c1 ctrl", c1_ctrl, 32'd0);
    check_eq("b2 c1 alu_b", c1_b, 32'd0);
    check_eq("b2 c2 ctrl", c2_ctrl, 32'd9);
    check_eq("b2 c2 alu_a", c2_a, 32'h00001234);
    check_eq("b2 c2 alu_b", c2_b, 32'd1);
    check_eq("b2 c3 ctrl", c3_ctrl, 32'd0);
    check_eq("b2 c3 alu_b", c3_b, 32'h00002468);

    // Back-to-back with start held high throughout
    exp_q.push_back(32'd18);
    exp_q.push_back(32'd18);
    bus.a = 32'd2;
    bus.b = 32'd9;
    bus.start = 1'b1;
    step();
    d1 = 0; d2 = 0; dn = 0;
    for (int c = 1; c <= 130; c++) begin
      if (bus.done) begin
        dn++;
        if (d1 == 0) d1 = c; else d2 = c;
        check_eq("b2b product", bus.product, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF);
      end
      if (c == 130) bus.start = 1'b0;
      step();
    end
    check_eq("b2b first done", 32'(d1), 32'd65);
    check_eq("b2b second done", 32'(d2), 32'd130);
    check_eq("b2b done count", 32'(dn), 32'd2);
    check_eq("b2b idle after", 32'(bus.state_dbg), 32'd0);

    // Asynchronous reset in the middle of cycle 20
    bus.a = 32'd5;
    bus.b = 32'd5;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (19) step();
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst busy", 32'(bus.busy), 32'd0);
    check_eq("arst alu_req", 32'(bus.alu_req), 32'd0);
    check_eq("arst alu_a", bus.alu_a, 32'd0);
    check_eq("arst alu_b", bus.alu_b, 32'd0);
    check_eq("arst alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    check_eq("arst product", bus.product, 32'd0);
    check_eq("arst state", 32'(bus.state_dbg), 32'd0);
    #1;
    reset = 1'b0;
    step();
    dn = 0;
    for (int c = 0; c < 70; c++) begin
      if (bus.done) dn++;
      step();
    end
    check_eq("arst no done", 32'(dn), 32'd0);

    // Cancel in cycle 30 keeps the previous product
    exp_q.push_back(32'd15);
    run_mult("pre-cancel", 32'd3, 32'd5);
    bus.a = 32'd6;
    bus.b = 32'd7;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (29) step();
    bus.cancel = 1'b1;
    step();
    bus.cancel = 1'b0;
    check_eq("cancel state", 32'(bus.state_dbg), 32'd0);
    check_eq("cancel busy", 32'(bus.busy), 32'd0);
    check_eq("cancel alu_req", 32'(bus.alu_req), 32'd0);
    check_eq("cancel product", bus.product, 32'd15);
    dn = 0;
    for (int c = 0; c < 70; c++) begin
      if (bus.done) dn++;
      step();
    end
    check_eq("cancel no done", 32'(dn), 32'd0);
    check_eq("cancel product later", bus.product, 32'd15);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
# mult_seq

Iterative 32-bit multiply sequencer for the DLX pipeline. Computes the low 32 bits of `a * b` by driving the shared ALU through 32 add/shift iterations: 64 cycles of ALU use plus one completion cycle. Sits beside the execute stage. While `alu_req` is high, the external ALU input mux routes `alu_a`/`alu_b`/`alu_ctrl` to the ALU and returns `ALUout` on `alu_result`. The low 32 bits are identical for signed and unsigned operands, so one path serves `mult` and `multu`.

## Interface
- No parameters; widths fixed at 32 data bits, 4 ctrl bits; bit 0 is MSB, bit 31 is LSB throughout.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: request a multiply. Sampled only in IDLE or DONE.
- `cancel` input 1: synchronous abort of an in-flight multiply.
- `a` input [0:31]: multiplicand, captured on accepted `start`.
- `b` input [0:31]: multiplier, captured on accepted `start`.
- `alu_result` input [0:31]: ALU output for the ALU inputs driven this cycle.
- `alu_req` output 1: request/ownership of the shared ALU.
- `alu_a` output [0:31]: ALU operand A.
- `alu_b` output [0:31]: ALU operand B.
- `alu_ctrl` output [0:3]: ALU function select.
- `busy` output 1: high in ADD or SHL.
- `done` output 1: one-cycle completion pulse.
- `product` output [0:31]: result register.

## Operation
- Registers:
  - `acc` [0:31]: accumulator.
  - `mcand` [0:31]: multiplicand, shifted left each iteration.
  - `mplier` [0:31]: multiplier, shifted right each iteration.
  - `iter` [0:4]: iteration counter.
  - `state`: IDLE, ADD, SHL, DONE.
- ALU function codes used: 4'b0000 add; 4'b1001 shift left logical, amount taken from B[27:31].
- **IDLE**:
  - `alu_req`=0, `alu_a`=0, `alu_b`=0, `alu_ctrl`=4'b0000.
  - On `start`=1: `acc`<=0, `mcand`<=`a`, `mplier`<=`b`, `iter`<=0, go to ADD.
- **ADD**:
  - `alu_req`=1, `alu_ctrl`=4'b0000, `alu_a`=`acc`.
  - `alu_b`=`mcand` if `mplier[31]`=1, else 0. Fixed latency; no skipping.
  - At the edge: `acc`<=`alu_result`. Go to SHL.
- **SHL**:
  - `alu_req`=1, `alu_ctrl`=4'b1001, `alu_a`=`mcand`, `alu_b`=32'd1.
  - At the edge: `mcand`<=`alu_result` and `mplier`<=`mplier`>>1 (internal, zero fill).
  - If `iter`=31, go to DONE. Otherwise `iter`<=`iter`+1 and go to ADD.
- **DONE**:
  - `alu_req`=0, `done`=1. `product` is loaded from `acc` on the SHL→DONE edge.
  - Next state is ADD if `start`=1 (new operands captured as in IDLE), else IDLE.
- Arithmetic is mod 2^32. Additions that carry beyond 32 bits, and the ALU `of` flag, are ignored.
- `product` holds its value until the next completion. It is not cleared by `start` or `cancel`.
- `start` in ADD or SHL is ignored; there is no queueing.
- `cancel`=1 in ADD or SHL: next state is IDLE, `done` is not pulsed, `product` is unchanged. `cancel` has no effect in IDLE or DONE.
- Same cycle as `cancel`: the in-flight register updates of that cycle are discarded.

## Timing
- Reset values: state IDLE; `acc`, `mcand`, `mplier`, `product` = 0; `iter` = 0; `busy`, `done`, `alu_req` = 0; `alu_a`, `alu_b` = 0; `alu_ctrl` = 4'b0000.
- Reset asserted mid-operation: immediate return to IDLE with the reset values above. No `done` pulse is generated.
- Count cycles from the edge that accepts `start` as cycle 0:
  - Cycles 1..64 are ADD/SHL alternating; iteration k has ADD in cycle 2k+1 and SHL in cycle 2k+2.
  - `done` and valid `product` appear in cycle 65. Latency is 65 cycles.
- All outputs are Moore (registered state only); none depend combinationally on `start`, `cancel` or `alu_result`.
- `alu_result` must be valid within the same cycle in which the ALU inputs are driven (ALU is combinational).
- Back-to-back: `start` asserted during DONE gives ADD in the next cycle, so throughput is one multiply per 65 cycles.

## Test plan
- `a`=3, `b`=5, `start` pulse → `busy` for cycles 1–64, `done` in cycle 65 only, `product`=32'd15; `alu_req` high exactly in cycles 1–64.
- `a`=32'hFFFFFFFD (−3), `b`=7 → `product`=32'hFFFFFFEB. Then `a`=`b`=32'hFFFFFFFF → `product`=32'h00000001.
- `a`=32'h00010000, `b`=32'h00010000 → `product`=0 (wrap). Also `a`=0, `b`=32'h12345678 → `product`=0, still 65-cycle latency.
- `start` held high continuously with `a`=2, `b`=9 → `done` in cycles 65 and 130, `product`=18 each time; `start` pulses in cycles 10–60 have no effect.
- `reset` pulsed asynchronously mid-cycle 20 → all outputs at reset values before the next edge, no `done`. Separately, `cancel` in cycle 30 → IDLE in cycle 31, `product` keeps its prior value (e.g. 15).
- Check `alu_ctrl`/`alu_b` per cycle for `b`=32'h00000002: cycle 1 ADD with `alu_b`=0, cycle 2 SHL with `alu_ctrl`=4'b1001 and `alu_b`=1, cycle 3 ADD with `alu_b`=`a`<<1.
